// File: rtl/tile_flusher.sv
// Streams a painted tile buffer out as row-major pixels with screen coordinates.
// BRAM read latency is absorbed by a credit-limited skid FIFO so backpressure never drops data.
//
// state  | meaning
// IDLE   | waiting for active; offsets sampled on exit
// STREAM | issuing tile reads while credits allow
// DRAIN  | all reads issued, emptying pipe and FIFO
// DONE   | every pixel accepted; done held while active stays high
module tile_flusher #(
   parameter int TILE_WIDTH   = 20,
   parameter int TILE_HEIGHT  = 45,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        active,
   input  logic [8:0]  x_offset,
   input  logic [7:0]  y_offset,
   output logic [9:0]  tile_bram_read_addr,
   input  logic [31:0] tile_bram_read_data,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [31:0] pixel_data,
   output logic [8:0]  pixel_x,
   output logic [7:0]  pixel_y,
   output logic        pixel_last,
   output logic        done
);

   localparam int CW = $clog2(TILE_WIDTH);
   localparam int RW = $clog2(TILE_HEIGHT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(TILE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(TILE_HEIGHT - 1);
   localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
   localparam logic [NW:0]   CREDITS = (NW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state;
   logic [8:0]    x_lat;
   logic [7:0]    y_lat;
   logic [CW-1:0] rd_col;
   logic [RW-1:0] rd_row;
   logic [9:0]    rd_addr;
   logic [9:0]    addr_q;

   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0] plast;
   logic [CW-1:0]           pcol [READ_LATENCY];
   logic [RW-1:0]           prow [READ_LATENCY];

   logic [31:0]           f_data [FIFO_DEPTH];
   logic [8:0]            f_x    [FIFO_DEPTH];
   logic [7:0]            f_y    [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] f_last;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [NW-1:0]         fifo_count;
   logic [NW-1:0]         inflight;

   logic issue, push, pop, abort, rd_last;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + NW'(pv[i]);
   end

   // Credits count reads already in the tag pipe so every return is guaranteed a slot.
   assign abort   = !active;
   assign issue   = (state == S_STREAM) && active && (({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS);
   assign push    = pv[READ_LATENCY-1] && active;
   assign pop     = pixel_valid && pixel_ready;
   assign rd_last = (rd_col == COL_MAX) && (rd_row == ROW_MAX);

   assign tile_bram_read_addr = issue ? rd_addr : addr_q;
   assign pixel_valid = (fifo_count != '0);
   assign pixel_data  = f_data[rd_ptr];
   assign pixel_x     = f_x[rd_ptr];
   assign pixel_y     = f_y[rd_ptr];
   assign pixel_last  = pixel_valid && f_last[rd_ptr];
   assign done        = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         x_lat   <= '0;
         y_lat   <= '0;
         rd_col  <= '0;
         rd_row  <= '0;
         rd_addr <= '0;
         addr_q  <= '0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               state   <= S_STREAM;
               x_lat   <= x_offset;
               y_lat   <= y_offset;
               rd_col  <= '0;
               rd_row  <= '0;
               rd_addr <= '0;
            end
            S_STREAM: if (issue) begin
               addr_q  <= rd_addr;
               rd_addr <= rd_addr + 10'd1;
               if (rd_col == COL_MAX) begin
                  rd_col <= '0;
                  rd_row <= rd_row + 1'b1;
               end else begin
                  rd_col <= rd_col + 1'b1;
               end
               if (rd_last) state <= S_DRAIN;
            end
            S_DRAIN: if (pop && pixel_last) state <= S_DONE;
            default: state <= S_DONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv    <= '0;
         plast <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pcol[i] <= '0;
            prow[i] <= '0;
         end
      end else begin
         pv[0]    <= issue;
         plast[0] <= rd_last;
         pcol[0]  <= rd_col;
         prow[0]  <= rd_row;
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pv[i]    <= pv[i-1];
            plast[i] <= plast[i-1];
            pcol[i]  <= pcol[i-1];
            prow[i]  <= prow[i-1];
         end
         if (abort) pv <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         f_last     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            f_data[i] <= '0;
            f_x[i]    <= '0;
            f_y[i]    <= '0;
         end
      end else if (abort) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            f_data[wr_ptr] <= tile_bram_read_data;
            f_x[wr_ptr]    <= x_lat + 9'(pcol[READ_LATENCY-1]);
            f_y[wr_ptr]    <= y_lat + 8'(prow[READ_LATENCY-1]);
            f_last[wr_ptr] <= plast[READ_LATENCY-1];
            wr_ptr         <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && fifo_count == FULL_CNT));

endmodule

// File: tb/tb_tile_flusher.sv
// Directed bench for tile_flusher: BRAM model returns word[a]=a two cycles after the address.
module tb_tile_flusher;
   localparam int TW = 20;
   localparam int NBEATS = 900;

   logic        clk = 1'b0;
   logic        rst_n, active, pixel_ready;
   logic [8:0]  x_offset, pixel_x;
   logic [7:0]  y_offset, pixel_y;
   logic [9:0]  tile_bram_read_addr;
   logic [31:0] tile_bram_read_data = '0;
   logic [31:0] bram_s1 = '0;
   logic [31:0] pixel_data;
   logic        pixel_valid, pixel_last, done;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bram_s1             <= {22'd0, tile_bram_read_addr};
      tile_bram_read_data <= bram_s1;
   end

   tile_flusher dut (
      .clk(clk), .rst_n(rst_n), .active(active),
      .x_offset(x_offset), .y_offset(y_offset),
      .tile_bram_read_addr(tile_bram_read_addr), .tile_bram_read_data(tile_bram_read_data),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_last(pixel_last), .done(done)
   );

   // Called #1 after a clock edge; leaves active high with new offsets, ready to be sampled.
   task automatic start_flush(input logic [8:0] xo, input logic [7:0] yo);
      active = 1'b0;
      @(posedge clk); #1;
      x_offset = xo;
      y_offset = yo;
      active = 1'b1;
   endtask

   task automatic consume(input logic [8:0] xo, input logic [7:0] yo, input int end_k,
                          input int pct, input string name);
      int k = 0;
      int cyc = 0;
      int maxc = 0;
      logic stall = 1'b0;
      logic [49:0] held = '0;
      logic [49:0] cur, exp_f;
      while (k < end_k && cyc < 6000) begin
         pixel_ready = ($urandom_range(99) < pct);
         cur = {pixel_data, pixel_x, pixel_y, pixel_last};
         if (stall) begin
            n_checks++;
            if (!pixel_valid || cur !== held) begin
               n_fail++;
               $display("FAIL %s stall_hold beat %0d: valid=%b fields=%h, required valid=1 fields=%h",
                        name, k, pixel_valid, cur, held);
            end
         end
         if (pixel_valid && pixel_ready) begin
            exp_f = {32'(k), xo + 9'(k % TW), yo + 8'(k / TW), (k == NBEATS - 1)};
            n_checks++;
            if (cur !== exp_f) begin
               n_fail++;
               $display("FAIL %s beat %0d: data=%0d x=%0d y=%0d last=%b, required data=%0d x=%0d y=%0d last=%b",
                        name, k, cur[49:18], cur[17:9], cur[8:1], cur[0],
                        exp_f[49:18], exp_f[17:9], exp_f[8:1], exp_f[0]);
            end
            k++;
         end
         stall = pixel_valid && !pixel_ready;
         held = cur;
         if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++;
      if (k != end_k) begin
         n_fail++;
         $display("FAIL %s timeout: beats=%0d, required %0d", name, k, end_k);
      end
      n_checks++;
      if (maxc > 4) begin
         n_fail++;
         $display("FAIL %s fifo_count max=%0d, required <= 4", name, maxc);
      end
      if (end_k == NBEATS) begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({done, pixel_valid} !== 2'b10) begin
               n_fail++;
               $display("FAIL %s done_hold cycle %0d: done=%b valid=%b, required done=1 valid=0",
                        name, i, done, pixel_valid);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; active = 1'b0; pixel_ready = 1'b0; x_offset = '0; y_offset = '0;
      #2;
      n_checks++;
      if ({tile_bram_read_addr, pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last, done} !== 62'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: addr=%0d valid=%b data=%0d x=%0d y=%0d last=%b done=%b, required all 0",
                  tile_bram_read_addr, pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last, done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({pixel_valid, done, tile_bram_read_addr} !== 12'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: valid=%b done=%b addr=%0d, required 0 0 0",
                  pixel_valid, done, tile_bram_read_addr);
      end
   endtask

   task automatic test_full_stream();
      pixel_ready = 1'b1;
      start_flush(9'd100, 8'd50);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early edge %0d: valid=%b, required 0", i, pixel_valid);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (pixel_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_first: valid=%b, required 1 four edges after active", pixel_valid);
      end
      consume(9'd100, 8'd50, NBEATS, 100, "full");
   endtask

   task automatic test_random_ready();
      start_flush(9'd100, 8'd50);
      consume(9'd100, 8'd50, NBEATS, 30, "random_ready");
   endtask

   task automatic test_backpressure();
      pixel_ready = 1'b0;
      start_flush(9'd100, 8'd50);
      repeat (50) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (tile_bram_read_addr !== 10'd3) begin
         n_fail++;
         $display("FAIL stall_reads: last addr=%0d, required 3", tile_bram_read_addr);
      end
      n_checks++;
      if ({pixel_valid, pixel_data} !== {1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL stall_head: valid=%b data=%0d, required 1 0", pixel_valid, pixel_data);
      end
      consume(9'd100, 8'd50, NBEATS, 100, "backpressure");
   endtask

   task automatic test_abort();
      start_flush(9'd100, 8'd50);
      consume(9'd100, 8'd50, 201, 100, "abort_pre");
      active = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({pixel_valid, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort cycle %0d: valid=%b done=%b, required 0 0", i, pixel_valid, done);
         end
      end
      start_flush(9'd0, 8'd0);
      consume(9'd0, 8'd0, NBEATS, 100, "after_abort");
   endtask

   task automatic test_wrap();
      start_flush(9'd500, 8'd250);
      consume(9'd500, 8'd250, NBEATS, 100, "wrap");
   endtask

   task automatic test_async_reset();
      start_flush(9'd100, 8'd50);
      consume(9'd100, 8'd50, 100, 100, "pre_reset");
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tile_bram_read_addr, pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last, done} !== 62'd0) begin
         n_fail++;
         $display("FAIL async_reset: addr=%0d valid=%b data=%0d x=%0d y=%0d last=%b done=%b, required all 0",
                  tile_bram_read_addr, pixel_valid, pixel_data, pixel_x, pixel_y, pixel_last, done);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      consume(9'd100, 8'd50, NBEATS, 100, "post_reset");
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_random_ready();
      test_backpressure();
      test_abort();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tile_flusher.md
Name: tile_flusher

Overview:
- Drains a fully painted tile buffer (TILE_WIDTH x TILE_HEIGHT words of 32 bits, row-major, addr = row*TILE_WIDTH + col) out to the frame-buffer writer.
- Runs as a valid/ready pixel stream with absolute screen coordinates.
- Reads the tile BRAM port that the tile painter writes, and runs after painting completes and before the tile is wiped.
- Absorbs the fixed BRAM read latency under downstream backpressure using a credit-limited skid FIFO.

Parameters:
TILE_WIDTH, 20, pixels per tile row
TILE_HEIGHT, 45, rows per tile
READ_LATENCY, 2, cycles from tile_bram_read_addr to tile_bram_read_data
FIFO_DEPTH, 4, skid FIFO entries; must be >= READ_LATENCY+2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
active  input  1  level; high starts/continues a flush, low aborts and returns to IDLE
x_offset  input  9  screen x of tile top-left, sampled on IDLE->STREAM
y_offset  input  8  screen y of tile top-left, sampled on IDLE->STREAM
tile_bram_read_addr  output  10  tile BRAM read address
tile_bram_read_data  input  32  read data, READ_LATENCY cycles after address
pixel_valid  output  1  stream valid
pixel_ready  input  1  stream ready from frame-buffer writer
pixel_data  output  32  tile word, unmodified
pixel_x  output  9  x_offset_latched + col, mod 512
pixel_y  output  8  y_offset_latched + row, mod 256
pixel_last  output  1  high with the final pixel (col TILE_WIDTH-1, row TILE_HEIGHT-1)
done  output  1  held high in DONE

Behaviour:
- Async reset (rst_n low): state IDLE; FIFO empty; read counters 0; in-flight valid pipe cleared.
- Async reset output values: tile_bram_read_addr=0, pixel_valid=0, pixel_data=0, pixel_x=0, pixel_y=0, pixel_last=0, done=0.
- IDLE -> STREAM: active high; latch offsets; rd_col=rd_row=0.
- STREAM issue rule: issue a read on any cycle where fifo_count + inflight < FIFO_DEPTH. Issuing drives addr = rd_row*TILE_WIDTH + rd_col and pushes a valid bit, with its col/row/last tags, into a READ_LATENCY-deep tag pipe.
- STREAM counters: advance col 0..TILE_WIDTH-1, then row 0..TILE_HEIGHT-1.
- STREAM -> DRAIN: after issuing the final address.
- When unissued, tile_bram_read_addr holds its last value.
- Data return: pipe-out valid writes {data, tags} into the FIFO. The FIFO never overflows because credits guarantee space. Overflow is an assertion failure.
- Output: pixel_valid = FIFO non-empty. Head fields drive pixel_data/x/y/last, combinationally from registered FIFO storage.
- Pop when pixel_valid && pixel_ready. Simultaneous push and pop in one cycle is allowed; count is unchanged.
- Stream values hold stable while valid && !ready.
- Ordering: strictly row-major, exactly TILE_WIDTH*TILE_HEIGHT (900) transfers per flush, no gaps in sequence, no duplicates.
- DRAIN -> DONE: the cycle after the last-tagged pixel is accepted (FIFO empty, inflight 0).
- DONE: done=1; pixel_valid=0; no reads issued; stays in DONE while active is high.
- active low in any state (synchronous): next cycle state=IDLE, FIFO flushed, tag pipe valids cleared, pixel_valid=0, done=0. Data returning from aborted reads is discarded.
- active re-raised in IDLE starts a fresh flush with newly sampled offsets. Re-raising needs at least one low cycle between flushes.
- Throughput with pixel_ready held high: one pixel/cycle after initial latency.
- First pixel_valid arrives READ_LATENCY+1 cycles after entering STREAM, i.e. READ_LATENCY+2 cycles after active rises.
- Coordinate adds wrap modulo port width; no saturation.

Test Plan:
- BRAM model word[a]=a, offsets (100,50), ready=1 -> 900 beats. Beat k has data k, x=100+k%20, y=50+k/20. pixel_last only on beat 899 (x=119, y=94). done rises 1 cycle after beat 899 and holds.
- Same flush with ready random 30% -> identical 900-beat sequence. No drops or duplicates; fields stable while stalled. FIFO count never exceeds 4.
- Ready held low 50 cycles at start -> at most 4 reads issued. Release ready -> stream resumes at beat 0, correct order.
- Deassert active after beat 200 accepted, with 3 reads in flight -> pixel_valid=0 the next cycle, done=0. Reassert with offsets (0,0) -> beat 0 has data 0, x=0, y=0.
- Offsets (500,250) -> beat 19 x=(519 mod 512)=7; beat 899 y=(294 mod 256)=38.
- rst_n low mid-STREAM, asynchronously -> all outputs 0 immediately without a clock edge. After release with active high -> full correct flush.
